// File: rtl/ttest_hls_deadlock_report_pkg.sv
// ============================================================================
// Package : tTest_hls_deadlock_pkg
// Purpose : Shared types and default widths for the deadlock report block.
//           Provides the report FSM state enum and the default sizes of the
//           snapshot vectors, the event counter and the persistence counter.
// Ports   : none (package)
// Config  : TTEST_DEADLOCK_TIMESTAMP_EN is consumed by the top module only.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package tTest_hls_deadlock_pkg;

  localparam int DEF_NUM_PROC       = 12;
  localparam int DEF_NUM_AXIS       = 2;
  localparam int DEF_CNT_W          = 16;
  localparam int DEF_PERSIST_CYCLES = 16;

  // The persistence count must reach PERSIST_CYCLES-1, and the legal
  // maximum for PERSIST_CYCLES is 65535, so 16 bits always suffices.
  localparam int PCNT_W = 16;

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    QUALIFY = 2'd1,
    LATCHED = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/ttest_hls_deadlock_report_ts_counter.sv
// ============================================================================
// Module  : tTest_hls_deadlock_ts_counter
// Purpose : Free-running CNT_W-bit cycle counter used as the detection
//           timestamp source. Zero after reset, +1 per clock, wraps.
// Ports   : clock  - rising-edge clock
//           reset  - synchronous active-low reset
//           count  - current counter value
// Config  : instantiated only when TTEST_DEADLOCK_TIMESTAMP_EN is defined.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tTest_hls_deadlock_ts_counter
  import tTest_hls_deadlock_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/ttest_hls_deadlock_report.sv
// ============================================================================
// Module  : ttest_hls_deadlock_report
// Purpose : Qualifies the deadlock monitor's block output over
//           PERSIST_CYCLES consecutive cycles, then freezes a snapshot of the
//           idle / channel-block / AXIS-block vectors, raises a sticky flag
//           and a one-cycle interrupt, and holds everything until software
//           clears it through clr_req / clr_ack.
// Ports   : clock           - rising-edge clock
//           reset           - synchronous active-low reset
//           block_in        - monitor block output
//           inst_idle_sigs  - per-process idle vector
//           inst_block_sigs - per-process channel-block vector
//           axis_block_sigs - AXIS block vector
//           clr_req         - level clear request (acted on only when latched)
//           clr_ack         - one-cycle pulse when a clear is taken
//           deadlock_flag   - sticky detection flag
//           deadlock_irq    - one-cycle pulse per detection
//           snap_idle/snap_block/snap_axis - vectors captured at detection
//           event_cnt       - saturating detection count since reset
//           snap_ts         - cycle timestamp of the detection
// Config  : TTEST_DEADLOCK_TIMESTAMP_EN - builds the cycle counter feeding
//           snap_ts; when undefined snap_ts is constant zero.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module ttest_hls_deadlock_report
  import tTest_hls_deadlock_pkg::*;
#(
  parameter int NUM_PROC       = DEF_NUM_PROC,
  parameter int NUM_AXIS       = DEF_NUM_AXIS,
  parameter int PERSIST_CYCLES = DEF_PERSIST_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                block_in,
  input  logic [NUM_PROC-1:0] inst_idle_sigs,
  input  logic [NUM_PROC-1:0] inst_block_sigs,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic                clr_req,
  output logic                clr_ack,
  output logic                deadlock_flag,
  output logic                deadlock_irq,
  output logic [NUM_PROC-1:0] snap_idle,
  output logic [NUM_PROC-1:0] snap_block,
  output logic [NUM_AXIS-1:0] snap_axis,
  output logic [CNT_W-1:0]    event_cnt,
  output logic [CNT_W-1:0]    snap_ts
);

  localparam logic [PCNT_W-1:0] c_pcnt_last = PCNT_W'(PERSIST_CYCLES - 1);
  localparam logic              c_single    = 1'(PERSIST_CYCLES == 1);
  localparam logic [CNT_W-1:0]  c_cnt_max   = '1;

  state_e               r_state;
  logic [PCNT_W-1:0]    r_pcnt;
  logic                 r_flag;
  logic                 r_irq;
  logic                 r_ack;
  logic [NUM_PROC-1:0]  r_snap_idle;
  logic [NUM_PROC-1:0]  r_snap_block;
  logic [NUM_AXIS-1:0]  r_snap_axis;
  logic [CNT_W-1:0]     r_event_cnt;
  logic [CNT_W-1:0]     r_snap_ts;

  logic [CNT_W-1:0]     w_ts;
  logic                 w_detect;

`ifdef TTEST_DEADLOCK_TIMESTAMP_EN
  tTest_hls_deadlock_ts_counter #(
    .CNT_W (CNT_W)
  ) u_ts_counter (
    .clock (clock),
    .reset (reset),
    .count (w_ts)
  );
`else
  assign w_ts = '0;
`endif

  // Detection edge: either a single-cycle persistence requirement met
  // straight from MONITOR, or the last qualifying cycle in QUALIFY.
  assign w_detect = block_in &
                    (((r_state == MONITOR) & c_single) |
                     ((r_state == QUALIFY) & (r_pcnt == c_pcnt_last)));

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= MONITOR;
      r_pcnt       <= '0;
      r_flag       <= 1'b0;
      r_irq        <= 1'b0;
      r_ack        <= 1'b0;
      r_snap_idle  <= '0;
      r_snap_block <= '0;
      r_snap_axis  <= '0;
      r_event_cnt  <= '0;
      r_snap_ts    <= '0;
    end else begin
      r_irq <= 1'b0;
      r_ack <= 1'b0;

      if (w_detect) begin
        r_state      <= LATCHED;
        r_pcnt       <= '0;
        r_flag       <= 1'b1;
        r_irq        <= 1'b1;
        r_snap_idle  <= inst_idle_sigs;
        r_snap_block <= inst_block_sigs;
        r_snap_axis  <= axis_block_sigs;
        r_snap_ts    <= w_ts;
        if (r_event_cnt != c_cnt_max) begin
          r_event_cnt <= r_event_cnt + CNT_W'(1);
        end
      end else begin
        case (r_state)
          MONITOR: begin
            if (block_in) begin
              r_state <= QUALIFY;
              r_pcnt  <= PCNT_W'(1);
            end
          end
          QUALIFY: begin
            if (!block_in) begin
              r_state <= MONITOR;
              r_pcnt  <= '0;
            end else begin
              r_pcnt <= r_pcnt + PCNT_W'(1);
            end
          end
          LATCHED: begin
            // Snapshot registers are deliberately left untouched on clear.
            if (clr_req) begin
              r_state <= MONITOR;
              r_flag  <= 1'b0;
              r_ack   <= 1'b1;
            end
          end
          default: begin
            r_state <= MONITOR;
            r_pcnt  <= '0;
          end
        endcase
      end
    end
  end

  assign clr_ack       = r_ack;
  assign deadlock_flag = r_flag;
  assign deadlock_irq  = r_irq;
  assign snap_idle     = r_snap_idle;
  assign snap_block    = r_snap_block;
  assign snap_axis     = r_snap_axis;
  assign event_cnt     = r_event_cnt;
  assign snap_ts       = r_snap_ts;

endmodule

`default_nettype wire

// File: tb/tb_ttest_hls_deadlock_report.sv
// ============================================================================
// Module  : tb_ttest_hls_deadlock_report
// Purpose : Self-checking bench for ttest_hls_deadlock_report. Two instances
//           share one stimulus stream: A uses PERSIST_CYCLES=4 / CNT_W=16,
//           B uses PERSIST_CYCLES=1 / CNT_W=2. A behavioural model based on
//           run lengths of block_in predicts every output of both each cycle.
// Config  : honours TTEST_DEADLOCK_TIMESTAMP_EN for snap_ts expectations.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ttest_hls_deadlock_report;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        block_in = 1'b0;
  logic        clr_req = 1'b0;
  logic [11:0] idle = '0;
  logic [11:0] blk = '0;
  logic [1:0]  axis = '0;

  logic        a_ack, a_flag, a_irq;
  logic [11:0] a_sidle, a_sblk;
  logic [1:0]  a_sax;
  logic [15:0] a_cnt, a_ts;

  logic        b_ack, b_flag, b_irq;
  logic [11:0] b_sidle, b_sblk;
  logic [1:0]  b_sax;
  logic [1:0]  b_cnt, b_ts;

  always #5 clock = ~clock;

  ttest_hls_deadlock_report #(
    .NUM_PROC(12), .NUM_AXIS(2), .PERSIST_CYCLES(4), .CNT_W(16)
  ) dut_a (
    .clock(clock), .reset(reset), .block_in(block_in),
    .inst_idle_sigs(idle), .inst_block_sigs(blk), .axis_block_sigs(axis),
    .clr_req(clr_req), .clr_ack(a_ack), .deadlock_flag(a_flag),
    .deadlock_irq(a_irq), .snap_idle(a_sidle), .snap_block(a_sblk),
    .snap_axis(a_sax), .event_cnt(a_cnt), .snap_ts(a_ts)
  );

  ttest_hls_deadlock_report #(
    .NUM_PROC(12), .NUM_AXIS(2), .PERSIST_CYCLES(1), .CNT_W(2)
  ) dut_b (
    .clock(clock), .reset(reset), .block_in(block_in),
    .inst_idle_sigs(idle), .inst_block_sigs(blk), .axis_block_sigs(axis),
    .clr_req(clr_req), .clr_ack(b_ack), .deadlock_flag(b_flag),
    .deadlock_irq(b_irq), .snap_idle(b_sidle), .snap_block(b_sblk),
    .snap_axis(b_sax), .event_cnt(b_cnt), .snap_ts(b_ts)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = instance A, 1 = instance B.
  int          m_p[2]   = '{4, 1};
  logic [15:0] m_max[2] = '{16'hFFFF, 16'h0003};
  int          m_streak[2];
  bit          m_lat[2], m_irq[2], m_ack[2];
  logic [15:0] m_cnt[2], m_ts[2];
  logic [11:0] m_idle[2], m_blk[2];
  logic [1:0]  m_ax[2];
  logic [15:0] m_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the model: a detection happens once block_in has been
  // seen high for P consecutive non-latched edges; latched ignores all but clr_req.
  task automatic model_edge();
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        m_streak[d] = 0; m_lat[d] = 0; m_irq[d] = 0; m_ack[d] = 0;
        m_cnt[d] = 0; m_ts[d] = 0; m_idle[d] = 0; m_blk[d] = 0; m_ax[d] = 0;
      end
      m_cyc = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_irq[d] = 0;
        m_ack[d] = 0;
        if (m_lat[d]) begin
          if (clr_req) begin
            m_lat[d] = 0;
            m_ack[d] = 1;
            m_streak[d] = 0;
          end
        end else if (block_in) begin
          m_streak[d]++;
          if (m_streak[d] >= m_p[d]) begin
            m_lat[d] = 1;
            m_irq[d] = 1;
            m_streak[d] = 0;
            m_idle[d] = idle;
            m_blk[d] = blk;
            m_ax[d] = axis;
            if (m_cnt[d] != m_max[d]) m_cnt[d] = m_cnt[d] + 16'd1;
            m_ts[d] = m_cyc & m_max[d];
          end
        end else begin
          m_streak[d] = 0;
        end
      end
      m_cyc = m_cyc + 16'd1;
    end
  endtask

  task automatic check_all();
    logic [15:0] ets_a, ets_b;
`ifdef TTEST_DEADLOCK_TIMESTAMP_EN
    ets_a = m_ts[0];
    ets_b = m_ts[1];
`else
    ets_a = 16'd0;
    ets_b = 16'd0;
`endif
    chk("A.flag", a_flag, m_lat[0]);
    chk("A.irq", a_irq, m_irq[0]);
    chk("A.ack", a_ack, m_ack[0]);
    chk("A.cnt", a_cnt, m_cnt[0]);
    chk("A.snap_idle", a_sidle, m_idle[0]);
    chk("A.snap_block", a_sblk, m_blk[0]);
    chk("A.snap_axis", a_sax, m_ax[0]);
    chk("A.snap_ts", a_ts, ets_a);
    chk("B.flag", b_flag, m_lat[1]);
    chk("B.irq", b_irq, m_irq[1]);
    chk("B.ack", b_ack, m_ack[1]);
    chk("B.cnt", b_cnt, m_cnt[1]);
    chk("B.snap_idle", b_sidle, m_idle[1]);
    chk("B.snap_block", b_sblk, m_blk[1]);
    chk("B.snap_axis", b_sax, m_ax[1]);
    chk("B.snap_ts", b_ts, ets_b);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic check_a_reset(input string tag);
    chk({tag, ".flag"}, a_flag, 0);
    chk({tag, ".irq"}, a_irq, 0);
    chk({tag, ".ack"}, a_ack, 0);
    chk({tag, ".cnt"}, a_cnt, 0);
    chk({tag, ".snap"}, {a_sidle, a_sblk, a_sax}, 0);
    chk({tag, ".ts"}, a_ts, 0);
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    repeat (3) step();
    check_a_reset("rst");
    reset = 1'b1;

    // Three-cycle pulse on A must not qualify
    block_in = 1'b1;
    repeat (3) step();
    block_in = 1'b0;
    step();
    chk("short.flag", a_flag, 0);
    chk("short.cnt", a_cnt, 0);

    // Four qualifying cycles with a known pattern on the detection edge
    block_in = 1'b1;
    idle = 12'h0F0; blk = 12'hF0F; axis = 2'b10;
    repeat (3) step();
    chk("qual3.flag", a_flag, 0);
    step();
    chk("det.flag", a_flag, 1);
    chk("det.irq", a_irq, 1);
    chk("det.cnt", a_cnt, 1);
    idle = 12'h123; blk = 12'h456; axis = 2'b01;
    step();
    chk("det+1.irq", a_irq, 0);
    chk("hold.idle", a_sidle, 12'h0F0);
    chk("hold.block", a_sblk, 12'hF0F);
    chk("hold.axis", a_sax, 2'b10);

    // Clear held for 5 cycles with block_in still high: one ack, requalify
    clr_req = 1'b1;
    step();
    chk("clr.ack", a_ack, 1);
    chk("clr.flag", a_flag, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("clrheld.ack", a_ack, 0);
      chk("clrheld.flag", a_flag, 0);
    end
    step();
    chk("redet.flag", a_flag, 1);
    chk("redet.ack", a_ack, 0);
    chk("redet.cnt", a_cnt, 2);
    clr_req = 1'b0;
    step();

    // Six detect/clear rounds on B saturate its 2-bit counter
    for (int i = 0; i < 6; i++) begin
      block_in = 1'b1; clr_req = 1'b0;
      step();
      clr_req = 1'b1;
      step();
    end
    chk("sat.cnt", b_cnt, 2'd3);

    // Reset while A is qualifying, then while A is latched
    block_in = 1'b0; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step();
    block_in = 1'b1;
    step();
    reset = 1'b0;
    step();
    check_a_reset("rstq");
    reset = 1'b1;
    repeat (4) step();
    chk("relatch.flag", a_flag, 1);
    reset = 1'b0;
    step();
    check_a_reset("rstl");

    // Timestamp: block_in rises 10 cycles after reset release
    block_in = 1'b0;
    reset = 1'b1;
    repeat (10) step();
    block_in = 1'b1;
    repeat (4) step();
    chk("ts.flag", a_flag, 1);
`ifdef TTEST_DEADLOCK_TIMESTAMP_EN
    chk("ts.value", a_ts, 16'd13);
`else
    chk("ts.value", a_ts, 16'd0);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 63) != 0);
      block_in = ($urandom_range(0, 3) != 0);
      clr_req  = ($urandom_range(0, 3) == 0);
      idle     = 12'($urandom);
      blk      = 12'($urandom);
      axis     = 2'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
